// File: rtl/trace_dump_serializer.sv
// trace_dump_serializer: dumps the circular trace buffer oldest-first as a valid/ready word stream.
// Optional TRACE_DUMP_HEADER_EN prepends one header beat {TB_SIZE[15:0], wr_ptr[15:0]}.
module trace_dump_serializer #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int TB_SIZE     = 64,
    parameter int RAM_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dump_start,
    input  logic [$clog2(TB_SIZE)-1:0] wr_ptr,
    output logic                       rd_en,
    output logic [$clog2(TB_SIZE)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]      rd_vector [N],
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       freeze,
    output logic                       done
);
    localparam int AW = $clog2(TB_SIZE);
    localparam int EW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(RAM_LATENCY + 1);
    localparam logic [EW-1:0] LAST_EL  = EW'(N - 1);
    localparam logic [AW-1:0] LAST_VEC = AW'(TB_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef TRACE_DUMP_HEADER_EN
        HEADER,
`endif
        READ,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         rd_addr_q;
    logic [AW-1:0]         vec_cnt_q;
    logic [EW-1:0]         elem_q;
    logic [LW-1:0]         lat_cnt_q;
    logic [DATA_WIDTH-1:0] hold_q [N];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  rd_en_q, out_valid_q, out_last_q, busy_q, done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            vec_cnt_q   <= '0;
            elem_q      <= '0;
            lat_cnt_q   <= '0;
            hold_q      <= '{default: '0};
            out_data_q  <= '0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (dump_start) begin
                    rd_addr_q <= wr_ptr;
                    vec_cnt_q <= '0;
                    busy_q    <= 1'b1;
`ifdef TRACE_DUMP_HEADER_EN
                    out_valid_q <= 1'b1;
                    out_data_q  <= DATA_WIDTH'({16'(TB_SIZE), 16'(wr_ptr)});
                    state_q     <= HEADER;
`else
                    rd_en_q <= 1'b1;
                    state_q <= READ;
`endif
                end
`ifdef TRACE_DUMP_HEADER_EN
                HEADER: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    rd_en_q     <= 1'b1;
                    state_q     <= READ;
                end
`endif
                READ: begin
                    rd_en_q   <= 1'b0;
                    lat_cnt_q <= '0;
                    state_q   <= WAIT;
                end
                // READ is cycle 0, so the RAM word is valid on the last WAIT cycle
                WAIT: if (lat_cnt_q == LW'(RAM_LATENCY - 1)) begin
                    hold_q      <= rd_vector;
                    elem_q      <= '0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= rd_vector[0];
                    out_last_q  <= (vec_cnt_q == LAST_VEC) && (N == 1);
                    state_q     <= SHIFT;
                end else begin
                    lat_cnt_q <= lat_cnt_q + 1'b1;
                end
                SHIFT: if (out_ready) begin
                    if (elem_q == LAST_EL) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (vec_cnt_q == LAST_VEC) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            vec_cnt_q <= vec_cnt_q + 1'b1;
                            rd_addr_q <= (rd_addr_q == LAST_VEC) ? '0 : rd_addr_q + 1'b1;
                            rd_en_q   <= 1'b1;
                            state_q   <= READ;
                        end
                    end else begin
                        elem_q     <= elem_q + 1'b1;
                        out_data_q <= hold_q[elem_q + 1'b1];
                        out_last_q <= (vec_cnt_q == LAST_VEC) && (elem_q + 1'b1 == LAST_EL);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign freeze    = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_trace_dump_serializer.sv
// tb_trace_dump_serializer: random/directed dumps scored against a queue model of the expected beat stream.
module tb_trace_dump_serializer;
    localparam int N   = 4;
    localparam int TB  = 4;
    localparam int LAT = 1;
`ifdef TRACE_DUMP_HEADER_EN
    localparam int DW = 32;
    localparam int HB = 1;
`else
    localparam int DW = 8;
    localparam int HB = 0;
`endif
    localparam int BEATS = N * TB + HB;
    localparam int BUSY_CYC = TB * (1 + LAT + N) + 1 + HB;

    logic          clk = 0, reset_n = 0, dump_start = 0, out_ready = 1;
    logic [1:0]    wr_ptr = '0, rd_addr;
    logic          rd_en, out_valid, out_last, busy, freeze, done;
    logic [DW-1:0] rd_vector [N];
    logic [DW-1:0] out_data;
    logic [DW-1:0] mem [TB][N];

    int total = 0, bad = 0, beats = 0, done_cnt = 0, rdy_mode = 0, ph = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_v, stall_v;
    int addr_q[$];
    bit stall_p = 0;

    trace_dump_serializer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TB), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .dump_start(dump_start), .wr_ptr(wr_ptr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_vector(rd_vector),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .freeze(freeze), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_vector <= mem[rd_addr];

    always @(posedge clk) begin
        #1;
        ph = ph + 1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        else out_ready = 1'($urandom_range(0, 1));
    end

    // scoreboard: every accepted beat is popped from the model queue
    always @(negedge clk) begin
        if (!reset_n) stall_p = 0;
        else begin
            total++;
            if (freeze !== busy) begin
                bad++;
                $display("FAIL freeze_eq_busy got freeze=%b want %b", freeze, busy);
            end
            if (stall_p) begin
                total++;
                if (out_valid !== 1'b1 || {out_last, out_data} !== stall_v) begin
                    bad++;
                    $display("FAIL stall_hold got valid=%b beat=%h want 1/%h", out_valid, {out_last, out_data}, stall_v);
                end
            end
            if (rd_en) addr_q.push_back(int'(rd_addr));
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                beats++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat got %h want none", {out_last, out_data});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_v) begin
                        bad++;
                        $display("FAIL beat%0d got last/data=%h want %h", beats - 1, {out_last, out_data}, exp_v);
                    end
                end
            end
            stall_p = out_valid && !out_ready;
            stall_v = {out_last, out_data};
        end
    end

    task automatic build_exp(input int wp);
        exp_q.delete();
        if (HB == 1) exp_q.push_back({1'b0, DW'({16'(TB), 16'(wp)})});
        for (int v = 0; v < TB; v++)
            for (int e = 0; e < N; e++)
                exp_q.push_back({(v == TB - 1) && (e == N - 1), mem[(wp + v) % TB][e]});
    endtask

    task automatic fill_plan();
        for (int k = 0; k < TB; k++)
            for (int e = 0; e < N; e++) mem[k][e] = DW'(k * 16 + e);
    endtask

    task automatic do_dump(input int wp, input bit poke, output int bcyc, output bit to);
        build_exp(wp);
        beats = 0; done_cnt = 0; addr_q.delete(); bcyc = 0; to = 1;
        @(posedge clk); #2; wr_ptr = 2'(wp); dump_start = 1;
        @(posedge clk); #2; dump_start = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (busy) bcyc++;
            if (poke) dump_start = (c == 10) || done;
            if (done) begin to = 0; break; end
        end
        @(posedge clk); #2; dump_start = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({rd_en, out_valid, out_data, out_last, busy, freeze, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %b want 0", {rd_en, out_valid, out_data, out_last, busy, freeze, done});
        end
        #1 reset_n = 1;
    endtask

    task automatic test_basic(input int wp, input string nm);
        int bc; bit to;
        fill_plan(); rdy_mode = 0;
        do_dump(wp, 0, bc, to);
        total++;
        if (to || done_cnt != 1) begin bad++; $display("FAIL %s_done got cnt=%0d timeout=%0b want 1/0", nm, done_cnt, to); end
        total++;
        if (beats != BEATS || exp_q.size() != 0) begin bad++; $display("FAIL %s_beats got %0d left=%0d want %0d/0", nm, beats, exp_q.size(), BEATS); end
        total++;
        if (bc != BUSY_CYC) begin bad++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, bc, BUSY_CYC); end
        total++;
        if (addr_q.size() != TB) begin bad++; $display("FAIL %s_reads got %0d want %0d", nm, addr_q.size(), TB); end
        else for (int v = 0; v < TB; v++) begin
            total++;
            if (addr_q[v] != (wp + v) % TB) begin bad++; $display("FAIL %s_addr%0d got %0d want %0d", nm, v, addr_q[v], (wp + v) % TB); end
        end
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL %s_idle got busy=%b done=%b want 0/0", nm, busy, done); end
    endtask

    task automatic test_backpressure();
        int bc; bit to;
        fill_plan(); rdy_mode = 1;
        do_dump(2, 0, bc, to);
        rdy_mode = 0;
        total++;
        if (to || done_cnt != 1 || beats != BEATS || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_count got done=%0d beats=%0d left=%0d to=%0b want 1/%0d/0/0", done_cnt, beats, exp_q.size(), to, BEATS);
        end
    endtask

    task automatic test_ignore_start();
        int bc; bit to;
        fill_plan(); rdy_mode = 0;
        do_dump(1, 1, bc, to);
        total++;
        if (to || bc != BUSY_CYC || beats != BEATS) begin bad++; $display("FAIL ign_dump got busy=%0d beats=%0d to=%0b want %0d/%0d/0", bc, beats, to, BUSY_CYC, BEATS); end
        bc = 0;
        repeat (10) begin @(negedge clk); #1; if (busy || rd_en) bc++; end
        total++;
        if (bc != 0 || done_cnt != 1) begin bad++; $display("FAIL ign_restart got active=%0d done=%0d want 0/1", bc, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int bc; bit to, hit;
        fill_plan(); rdy_mode = 0; build_exp(0);
        beats = 0; done_cnt = 0; hit = 0;
        @(posedge clk); #2; wr_ptr = 2'd0; dump_start = 1;
        @(posedge clk); #2; dump_start = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (beats >= 5) begin hit = 1; break; end
        end
        total++;
        if (!hit || out_valid !== 1'b1) begin bad++; $display("FAIL rst_reach got hit=%0b valid=%b want 1/1", hit, out_valid); end
        reset_n = 0; #1;
        total++;
        if ({rd_en, out_valid, out_data, out_last, busy, freeze, done} !== '0) begin
            bad++;
            $display("FAIL rst_async got %b want 0", {rd_en, out_valid, out_data, out_last, busy, freeze, done});
        end
        repeat (2) @(negedge clk);
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL rst_no_done got %0d want 0", done_cnt); end
        #1 reset_n = 1;
        do_dump(3, 0, bc, to);
        total++;
        if (to || done_cnt != 1 || beats != BEATS || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_redump got done=%0d beats=%0d left=%0d want 1/%0d/0", done_cnt, beats, exp_q.size(), BEATS);
        end
    endtask

    task automatic test_random();
        int bc, wp; bit to;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < TB; k++)
                for (int e = 0; e < N; e++) mem[k][e] = DW'($urandom);
            wp = $urandom_range(0, TB - 1);
            rdy_mode = 2;
            do_dump(wp, 0, bc, to);
            rdy_mode = 0;
            total++;
            if (to || done_cnt != 1 || beats != BEATS || exp_q.size() != 0) begin
                bad++;
                $display("FAIL rnd%0d got done=%0d beats=%0d left=%0d want 1/%0d/0", it, done_cnt, beats, exp_q.size(), BEATS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(3, "wrap");
        test_backpressure();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
